// File: rtl/mux_rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter that feeds the
// 4:1 channel mux: channel count, select width, FSM states and helpers.
package mux_rr_sel_arbiter_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

    function automatic logic [NCH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] one;
        one = {{(NCH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux_rr_sel_arbiter_rr_priority_pick.sv
// Combinational rotating-priority pick: first set request bit scanning
// ptr, ptr+1, ... (mod 4). idx is only meaningful when found is high.
module rr_priority_pick
    import mux_rr_sel_arbiter_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;
    logic [SEL_W-1:0] w_off;

    // Rotate so bit 0 of w_rot is the channel at ptr.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: NCH];

    // Lowest set bit of the rotated vector is the closest channel to ptr.
    always_comb begin
        w_off = 2'd0;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else if (w_rot[3]) begin
            w_off = 2'd3;
        end else begin
            w_off = 2'd0;
        end
    end

    assign found = |w_rot;
    assign idx   = ptr + w_off;

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving sel1/sel2 of the 4:1 channel mux; holds a
// grant for up to MAX_BURST accepted beats with a valid/ready handshake.
module mux_rr_sel_arbiter
    import mux_rr_sel_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           out_ready,
    output logic           sel1,
    output logic           sel2,
    output logic [NCH-1:0] grant,
    output logic           out_valid,
    output logic           burst_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_cur;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic [NCH-1:0]   r_grant;
    logic             r_out_valid;

    arb_state_e       w_nxt_state;
    logic [SEL_W-1:0] w_nxt_ptr;
    logic [SEL_W-1:0] w_nxt_cur;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [SEL_W-1:0] w_nxt_sel;
    logic [NCH-1:0]   w_nxt_grant;
    logic             w_nxt_valid;

    logic             w_accept;
    logic             w_release;
    logic [SEL_W-1:0] w_pick_ptr;
    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    // One picker serves both paths: from ptr in IDLE, from cur+1 on release
    // so the releasing channel is examined last.
    assign w_pick_ptr = (r_state == IDLE) ? r_ptr : (r_cur + 2'd1);

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_accept  = r_out_valid & out_ready;
    assign w_release = (r_state == GRANT) &&
                       (!req[r_cur] || (w_accept && (r_cnt == LAST_CNT)));

    // State register: arbitration state, pointer, owner and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= CH0;
            r_cur   <= CH0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_cur   <= w_nxt_cur;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // Next-state logic: grant from IDLE, count accepts, release and re-arbitrate.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_cur   = r_cur;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nxt_state = GRANT;
                    w_nxt_cur   = w_idx;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nxt_ptr = r_cur + 2'd1;
                    w_nxt_cnt = '0;
                    if (w_found) begin
                        w_nxt_state = GRANT;
                        w_nxt_cur   = w_idx;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else if (w_accept) begin
                    w_nxt_cnt = r_cnt + CNT_ONE;
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Output decode of the next state; select holds its value through IDLE.
    always_comb begin
        w_nxt_valid = 1'b0;
        w_nxt_grant = '0;
        w_nxt_sel   = r_sel;
        if (w_nxt_state == GRANT) begin
            w_nxt_valid = 1'b1;
            w_nxt_grant = idx_to_onehot(w_nxt_cur);
            w_nxt_sel   = w_nxt_cur;
        end else begin
            w_nxt_valid = 1'b0;
            w_nxt_grant = '0;
            w_nxt_sel   = r_sel;
        end
    end

    // Output registers so mux selects and grant are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= CH0;
            r_grant     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_sel       <= w_nxt_sel;
            r_grant     <= w_nxt_grant;
            r_out_valid <= w_nxt_valid;
        end
    end

    assign sel1       = r_sel[0];
    assign sel2       = r_sel[1];
    assign grant      = r_grant;
    assign out_valid  = r_out_valid;
    assign burst_last = (r_state == GRANT) && (r_cnt == LAST_CNT);

endmodule

// File: doc/mux_rr_sel_arbiter.md
Name: mux_rr_sel_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 4:1 2-bit channel mux and drives its sel1/sel2 inputs. It grants one of four requesting sources and holds the grant for a bounded burst of accepted beats. It flags valid output to the downstream consumer with a valid/ready handshake, so the mux select never changes while a beat is stalled.

Parameters:
MAX_BURST, 4, maximum accepted beats per grant before forced rotation (legal range 1..7)
CNT_W, 3, width of the burst counter (must hold MAX_BURST-1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  per-source request; bit i = mux input in(i+1)
out_ready  input  1  downstream accepts the current beat
sel1  output  1  mux select LSB (channel index bit 0)
sel2  output  1  mux select MSB (channel index bit 1)
grant  output  4  one-hot grant, 0 when idle
out_valid  output  1  selected channel carries a valid beat
burst_last  output  1  current beat is the last of this grant (cnt == MAX_BURST-1)

Behaviour:
- Channel index = {sel2, sel1}: 00->in1, 01->in2, 10->in3, 11->in4.
- Reset (rst=1 at edge) gives sel1=0, sel2=0, grant=0, out_valid=0, burst_last=0, burst_cnt=0, priority ptr=0, state IDLE. Reset overrides any in-flight burst, and no beat is completed.
- State IDLE: if req!=0 at edge N, pick the first set bit scanning ptr, ptr+1, ... (mod 4). At N+1 the block is in GRANT: grant/sel reflect the winner, out_valid=1, burst_cnt=0. Latency from req to out_valid is 1 cycle. If req==0, stay IDLE.
- In IDLE, sel1/sel2 hold their last value and are not cleared. grant=0 and out_valid=0.
- State GRANT: accept = out_valid & out_ready. On accept, burst_cnt increments.
- Release conditions, evaluated at each edge in priority order:
  (a) req[cur]==0. Release immediately, even if stalled, and the pending beat is dropped.
  (b) accept and burst_cnt==MAX_BURST-1.
- On release: ptr = cur+1 mod 4, then re-arbitrate in the same edge, scanning from the new ptr with cur examined last.
  - If a winner exists, the next cycle is GRANT to the winner with burst_cnt=0 and no idle bubble.
  - Otherwise go to IDLE.
- Sole requester: with MAX_BURST reached and only cur requesting, cur is re-granted. burst_cnt restarts at 0 and out_valid stays high continuously.
- While out_valid=1 and out_ready=0 with req[cur] held, sel1/sel2/grant/burst_cnt are frozen.
- New requests from other channels never pre-empt a burst except via (a) or (b).
- burst_last is a combinational decode of GRANT & burst_cnt==MAX_BURST-1.
- grant is always one-hot or zero, and grant[{sel2,sel1}]==1 whenever out_valid=1.

Decomposition:
- Shared package holds:
  - NCH=4 and SEL_W=2.
  - The state enum {IDLE, GRANT}.
  - Channel index constants CH0..CH3.
- Sub-module rr_priority_pick is purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once and used for both the IDLE and release paths.

Test Plan:
- Reset then req=0000 for 5 cycles -> grant=0000, out_valid=0, sel1=0, sel2=0 throughout.
- req=0100, out_ready=1, MAX_BURST=4 -> next cycle grant=0100, sel2=1, sel1=0, out_valid=1. Four accepts occur with burst_last=1 on the 4th, then re-grant to ch2 with no gap.
- req=1111, out_ready=1 from reset -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001, and {sel2,sel1} steps 00,01,10,11,00.
- Grant ch1 and hold out_ready=0 for 6 cycles while req=1111 -> sel1=1, sel2=0, burst_cnt=0, out_valid=1 stay frozen. Raising out_ready resumes counting from 0.
- Grant ch3, drop req[3] mid-stall with req=0001 -> next cycle grant=0001, sel=00, out_valid=1. Dropping all req instead -> IDLE, out_valid=0, sel holds 11.
- Assert rst for 1 cycle mid-burst on ch2 -> next cycle all outputs at reset values, ptr=0. With req=0101, the next grant goes to ch0.
